// File: rtl/cart_rom_stager.sv
// Cartridge ROM download stager: packs ioctl halfwords into 32-bit SDRAM writes with byte-order normalisation.
// Optional CART_ROM_CRC_EN adds a checksum over the 0x1000..0x100FFF region (crc_ok / crc_val).
//
// state   | meaning
// IDLE    | no download; waiting for dl_active to rise
// LOW     | waiting for the low halfword (addr[1]=0) of the next word
// HIGH    | low half latched; waiting for the high halfword (addr[1]=1)
// ISSUE   | sd_req asserted for one cycle
// WAIT    | write outstanding; waiting for sd_ready
module cart_rom_stager #(
  parameter int CART_BASE = 1048576,
  parameter int ADDR_W    = 27
) (
  input  logic              clk1x,
  input  logic              reset,
  input  logic              dl_active,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [31:0]       sd_data,
  output logic              sd_req,
  input  logic              sd_ready,
  output logic [1:0]        rom_format,
  output logic [ADDR_W-1:0] rom_size,
  output logic              cart_loaded,
  output logic              overrun
`ifdef CART_ROM_CRC_EN
  ,
  output logic              crc_ok,
  output logic [31:0]       crc_val
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOW   = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(CART_BASE);

  logic [2:0]        state;
  logic              dl_q;
  logic              end_pend;
  logic [15:0]       lo_half;
  logic [ADDR_W-1:0] word_addr;

  logic              dl_rise;
  logic              dl_fall;
  logic              take_low;
  logic              take_high;
  logic [1:0]        fmt_next;
  logic [15:0]       pend_lo;
  logic [1:0]        pend_fmt;
  logic [ADDR_W-1:0] next_size;

  function automatic logic [1:0] fmt_of(input logic [15:0] hw);
    case (hw)
      16'h3780: fmt_of = 2'd0;
      16'h8037: fmt_of = 2'd1;
      16'h1240: fmt_of = 2'd2;
      default:  fmt_of = 2'd3;
    endcase
  endfunction

  // r0..r3 are the raw file bytes of the word in address order.
  function automatic logic [31:0] norm(input logic [1:0] fmt, input logic [15:0] lo, input logic [15:0] hi);
    case (fmt)
      2'd1:    norm = {hi[7:0], hi[15:8], lo[7:0], lo[15:8]};
      2'd2:    norm = {lo[7:0], lo[15:8], hi[7:0], hi[15:8]};
      default: norm = {hi[15:8], hi[7:0], lo[15:8], lo[7:0]};
    endcase
  endfunction

  assign dl_rise    = dl_active & ~dl_q;
  assign dl_fall    = ~dl_active & dl_q;
  assign ioctl_wait = (state == S_ISSUE) || (state == S_WAIT);
  assign sd_req     = (state == S_ISSUE);
  assign take_low   = ioctl_wr && !ioctl_addr[1] && ((state == S_LOW) || (state == S_HIGH));
  assign take_high  = ioctl_wr && ioctl_addr[1] && (state == S_HIGH);
  assign fmt_next   = (ioctl_addr == '0) ? fmt_of(ioctl_dout) : rom_format;
  // A low half arriving together with the end of download becomes the pending half.
  assign pend_lo    = take_low ? ioctl_dout : lo_half;
  assign pend_fmt   = take_low ? fmt_next : rom_format;
  assign next_size  = word_addr + ADDR_W'(4);

  always_ff @(posedge clk1x) begin
    if (reset) begin
      state       <= S_IDLE;
      dl_q        <= 1'b0;
      end_pend    <= 1'b0;
      lo_half     <= '0;
      word_addr   <= '0;
      sd_addr     <= '0;
      sd_data     <= '0;
      rom_format  <= '0;
      rom_size    <= '0;
      cart_loaded <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      dl_q <= dl_active;
      if (ioctl_wr && ioctl_wait)
        overrun <= 1'b1;

      if (take_low) begin
        lo_half   <= ioctl_dout;
        word_addr <= {ioctl_addr[ADDR_W-1:2], 2'b00};
        sd_addr   <= {ioctl_addr[ADDR_W-1:2], 2'b00} + BASE;
        if (ioctl_addr == '0)
          rom_format <= fmt_of(ioctl_dout);
      end

      case (state)
        S_IDLE: begin
          if (dl_rise) begin
            rom_size   <= '0;
            rom_format <= '0;
            end_pend   <= 1'b0;
            state      <= S_LOW;
          end
        end
        S_LOW, S_HIGH: begin
          if (take_high) begin
            sd_data  <= norm(rom_format, lo_half, ioctl_dout);
            end_pend <= dl_fall;
            state    <= S_ISSUE;
          end else if (dl_fall && (take_low || (state == S_HIGH))) begin
            sd_data  <= norm(pend_fmt, pend_lo, 16'h0000);
            end_pend <= 1'b1;
            state    <= S_ISSUE;
          end else if (take_low) begin
            state <= S_HIGH;
          end else if (dl_fall) begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          if (dl_fall)
            end_pend <= 1'b1;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (dl_fall)
            end_pend <= 1'b1;
          if (sd_ready) begin
            if (next_size > rom_size)
              rom_size <= next_size;
            cart_loaded <= 1'b1;
            state       <= (end_pend || dl_fall) ? S_IDLE : S_LOW;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CART_ROM_CRC_EN
  localparam logic [ADDR_W-1:0] CRC_LO   = ADDR_W'(32'h0000_1000);
  localparam logic [ADDR_W-1:0] CRC_LAST = ADDR_W'(32'h0010_0FFC);

  logic [31:0] w10;
  logic [31:0] w14;
  logic        in_range;
  logic [31:0] crc_sum;

  assign in_range = (word_addr >= CRC_LO) && (word_addr <= CRC_LAST);
  assign crc_sum  = crc_val + sd_data;

  always_ff @(posedge clk1x) begin
    if (reset) begin
      crc_ok  <= 1'b0;
      crc_val <= '0;
      w10     <= '0;
      w14     <= '0;
    end else if ((state == S_IDLE) && dl_rise) begin
      crc_ok  <= 1'b0;
      crc_val <= '0;
    end else if ((state == S_WAIT) && sd_ready) begin
      if (word_addr == ADDR_W'(32'h10))
        w10 <= sd_data;
      if (word_addr == ADDR_W'(32'h14))
        w14 <= sd_data;
      if (in_range)
        crc_val <= crc_sum;
      if (word_addr == CRC_LAST)
        crc_ok <= (crc_sum == (w10 ^ w14));
    end
  end
`endif

endmodule

// File: tb/tb_cart_rom_stager.sv
// Testbench for cart_rom_stager: scenario tasks plus an SDRAM responder that scores every write request.
module tb_cart_rom_stager;
  localparam int AW = 27;

  logic          clk1x = 1'b0;
  logic          reset;
  logic          dl_active;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [15:0]   ioctl_dout;
  logic          ioctl_wait;
  logic [AW-1:0] sd_addr;
  logic [31:0]   sd_data;
  logic          sd_req;
  logic          sd_ready;
  logic [1:0]    rom_format;
  logic [AW-1:0] rom_size;
  logic          cart_loaded;
  logic          overrun;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] mon_exp;
  int ready_delay = 1;
  bit early_ready = 1'b0;

  cart_rom_stager dut (
    .clk1x(clk1x), .reset(reset), .dl_active(dl_active), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .sd_addr(sd_addr), .sd_data(sd_data), .sd_req(sd_req), .sd_ready(sd_ready),
    .rom_format(rom_format), .rom_size(rom_size), .cart_loaded(cart_loaded), .overrun(overrun)
  );

  always #5 clk1x = ~clk1x;

  // SDRAM model: scores each request, then completes it ready_delay cycles later.
  initial begin
    int skip;
    sd_ready = 1'b0;
    forever begin
      @(negedge clk1x);
      if (sd_req === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sd_write: unexpected request addr=%h data=%h", sd_addr, sd_data);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({sd_addr, sd_data} !== mon_exp) begin
            n_fail++;
            $display("FAIL sd_write: got addr=%h data=%h want addr=%h data=%h",
                     sd_addr, sd_data, mon_exp[AW+31:32], mon_exp[31:0]);
          end
        end
        skip = ready_delay;
        if (early_ready) begin
          sd_ready = 1'b1;
          @(posedge clk1x);
          #1 sd_ready = 1'b0;
          skip--;
        end
        repeat (skip) @(posedge clk1x);
        #1 sd_ready = 1'b1;
        @(posedge clk1x);
        #1 sd_ready = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] norm(input int fmt, input logic [15:0] lo, input logic [15:0] hi);
    case (fmt)
      1:       return {hi[7:0], hi[15:8], lo[7:0], lo[15:8]};
      2:       return {lo[7:0], lo[15:8], hi[7:0], hi[15:8]};
      default: return {hi, lo};
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk1x);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick(1);
    ioctl_wr   = 1'b0;
  endtask

  task automatic push_exp(input logic [AW-1:0] wa, input logic [31:0] d);
    logic [AW-1:0] sa;
    sa = wa + 27'h100000;
    exp_q.push_back({sa, d});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (ioctl_wait === 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    n_tests++;
    if (ioctl_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: ioctl_wait got %b want 0 within 200 cycles", name, ioctl_wait);
    end
  endtask

  task automatic start_dl();
    dl_active = 1'b1;
    tick(2);
  endtask

  task automatic end_dl();
    dl_active = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    n_tests++;
    if ({ioctl_wait, sd_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_handshake: got wait/req=%b want 00", {ioctl_wait, sd_req});
    end
    n_tests++;
    if ({sd_addr, sd_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_datapath: got addr=%h data=%h want 0", sd_addr, sd_data);
    end
    n_tests++;
    if ({rom_format, rom_size, cart_loaded, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_status: got fmt=%0d size=%h loaded=%b ovr=%b want 0", rom_format, rom_size, cart_loaded, overrun);
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_formats();
    logic [15:0] h0 [3];
    logic [15:0] h1 [3];
    h0 = '{16'h3780, 16'h8037, 16'h1240};
    h1 = '{16'h4012, 16'h1240, 16'h8037};
    for (int f = 0; f < 3; f++) begin
      start_dl();
      wr(27'h0, h0[f]);
      push_exp(27'h0, 32'h40123780);
      wr(27'h2, h1[f]);
      wait_idle("format_hdr");
      n_tests++;
      if (rom_format !== 2'(f)) begin
        n_fail++;
        $display("FAIL format_detect: got %0d want %0d", rom_format, f);
      end
      wr(27'h6, 16'hFFFF);
      tick(2);
      wr(27'h4, 16'h1111);
      wr(27'h4, 16'hBBAA);
      push_exp(27'h4, norm(f, 16'hBBAA, 16'hDDCC));
      wr(27'h6, 16'hDDCC);
      wait_idle("format_word1");
      n_tests++;
      if (rom_size !== 27'd8 || cart_loaded !== 1'b1) begin
        n_fail++;
        $display("FAIL format_size: got size=%0d loaded=%b want 8/1", rom_size, cart_loaded);
      end
      end_dl();
      n_tests++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL format_writes: %0d expected writes missing, want 0", exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  task automatic test_handshake();
    int wcnt = 0;
    int rcnt = 0;
    logic first_req;
    start_dl();
    wr(27'h0, 16'h3780);
    push_exp(27'h0, 32'h40123780);
    ready_delay = 7;
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL hs_overrun_pre: got %b want 0", overrun);
    end
    wr(27'h2, 16'h4012);
    first_req = sd_req;
    while (ioctl_wait === 1'b1 && wcnt < 50) begin
      if (sd_req === 1'b1) rcnt++;
      ioctl_addr = 27'h4;
      ioctl_dout = 16'hAAAA;
      ioctl_wr   = (wcnt == 3);
      wcnt++;
      tick(1);
    end
    ioctl_wr = 1'b0;
    ready_delay = 1;
    n_tests++;
    if (first_req !== 1'b1 || rcnt != 1) begin
      n_fail++;
      $display("FAIL hs_req: got first=%b count=%0d want 1/1", first_req, rcnt);
    end
    n_tests++;
    if (wcnt != 8) begin
      n_fail++;
      $display("FAIL hs_wait_len: got %0d cycles want 8", wcnt);
    end
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL hs_overrun: got %b want 1", overrun);
    end
    end_dl();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL hs_writes: %0d expected writes missing, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_early_ready();
    int wcnt = 0;
    start_dl();
    wr(27'h0, 16'h3780);
    push_exp(27'h0, 32'h40123780);
    early_ready = 1'b1;
    ready_delay = 3;
    wr(27'h2, 16'h4012);
    while (ioctl_wait === 1'b1 && wcnt < 50) begin
      wcnt++;
      tick(1);
    end
    early_ready = 1'b0;
    ready_delay = 1;
    n_tests++;
    if (wcnt != 4) begin
      n_fail++;
      $display("FAIL early_ready: got wait %0d cycles want 4", wcnt);
    end
    end_dl();
  endtask

  task automatic test_odd_length();
    start_dl();
    wr(27'h0, 16'h3780);
    push_exp(27'h0, 32'h40123780);
    wr(27'h2, 16'h4012);
    wait_idle("odd_w0");
    push_exp(27'h4, 32'h0000BEEF);
    wr(27'h4, 16'hBEEF);
    dl_active = 1'b0;
    tick(1);
    wait_idle("odd_w1");
    tick(2);
    n_tests++;
    if (rom_size !== 27'd8) begin
      n_fail++;
      $display("FAIL odd_size: got %0d want 8", rom_size);
    end
    wr(27'h8, 16'h1234);
    wr(27'hA, 16'h5678);
    tick(4);
    n_tests++;
    if (ioctl_wait !== 1'b0 || rom_size !== 27'd8) begin
      n_fail++;
      $display("FAIL odd_idle: got wait=%b size=%0d want 0/8", ioctl_wait, rom_size);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL odd_writes: %0d expected writes missing, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_fall_with_wr();
    start_dl();
    wr(27'h0, 16'h8037);
    push_exp(27'h0, 32'h40123780);
    ioctl_addr = 27'h2;
    ioctl_dout = 16'h1240;
    ioctl_wr   = 1'b1;
    dl_active  = 1'b0;
    tick(1);
    ioctl_wr   = 1'b0;
    wait_idle("fall_wr");
    tick(3);
    n_tests++;
    if (rom_size !== 27'd4 || rom_format !== 2'd1) begin
      n_fail++;
      $display("FAIL fall_wr_status: got size=%0d fmt=%0d want 4/1", rom_size, rom_format);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fall_wr_writes: %0d expected writes missing, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    start_dl();
    wr(27'h0, 16'h3780);
    push_exp(27'h0, 32'h40123780);
    wr(27'h2, 16'h4012);
    wait_idle("b2b_w0");
    wr(27'h8, 16'h2211);
    push_exp(27'h8, norm(0, 16'h2211, 16'h4433));
    wr(27'hA, 16'h4433);
    wait_idle("b2b_w8");
    wr(27'h4, 16'h6655);
    push_exp(27'h4, norm(0, 16'h6655, 16'h8877));
    wr(27'h6, 16'h8877);
    wait_idle("b2b_w4");
    n_tests++;
    if (rom_size !== 27'd12) begin
      n_fail++;
      $display("FAIL b2b_size_max: got %0d want 12", rom_size);
    end
    wr(27'h7F00000, 16'hCAFE);
    push_exp(27'h7F00000, norm(0, 16'hCAFE, 16'hF00D));
    wr(27'h7F00002, 16'hF00D);
    wait_idle("b2b_wrap");
    n_tests++;
    if (rom_size !== 27'h7F00004) begin
      n_fail++;
      $display("FAIL b2b_size_wrap: got %h want 7f00004", rom_size);
    end
    end_dl();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_writes: %0d expected writes missing, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_in_wait();
    int rcnt = 0;
    start_dl();
    wr(27'h0, 16'h3780);
    push_exp(27'h0, 32'h40123780);
    ready_delay = 20;
    wr(27'h2, 16'h4012);
    tick(3);
    reset = 1'b1;
    dl_active = 1'b0;
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (sd_req === 1'b1) rcnt++;
      tick(1);
    end
    ready_delay = 1;
    n_tests++;
    if (rcnt != 0 || ioctl_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL rstw_req: got req_count=%0d wait=%b want 0/0", rcnt, ioctl_wait);
    end
    n_tests++;
    if (cart_loaded !== 1'b0 || rom_size !== '0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL rstw_status: got loaded=%b size=%0d ovr=%b want 0/0/0", cart_loaded, rom_size, overrun);
    end
    start_dl();
    wr(27'h0, 16'h1240);
    push_exp(27'h0, 32'h40123780);
    wr(27'h2, 16'h8037);
    wait_idle("rstw_new");
    n_tests++;
    if (rom_format !== 2'd2 || rom_size !== 27'd4 || cart_loaded !== 1'b1) begin
      n_fail++;
      $display("FAIL rstw_new_dl: got fmt=%0d size=%0d loaded=%b want 2/4/1", rom_format, rom_size, cart_loaded);
    end
    end_dl();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rstw_writes: %0d expected writes missing, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    reset      = 1'b1;
    dl_active  = 1'b0;
    ioctl_wr   = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    test_reset();
    test_formats();
    test_handshake();
    test_early_ready();
    test_odd_length();
    test_fall_with_wr();
    test_back_to_back();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
